// File: rtl/cpu_fetch_unit.sv
// cpu_fetch_unit: instruction fetch stage for the 4-bit SAP CPU.
//
// Holds the program counter and the memory address register (MAR). The MAR drives the
// program ROM address. Each ROM byte is captured into the instruction register (IR), which
// is offered to execute over a valid/ready handshake. Fetching one instruction takes three
// states: load MAR, capture IR, then present it.
//
// Optional feature: define CPU_FETCH_HALT_EN to stop fetching after an HLT_OPCODE
// instruction has been handed over. Only reset restarts the unit.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   mem_addr   out  MAR contents, ROM address
//   mem_data   in   ROM data (combinational from mem_addr)
//   ir_valid   out  IR holds an instruction for execute
//   ir_ready   in   execute accepts the IR this cycle
//   opcode     out  upper DATA_W-ADDR_W bits of IR
//   operand    out  lower ADDR_W bits of IR
//   pc         out  program counter (address of next fetch)
//   jump_en    in   redirect PC; taken only on a handshake
//   jump_addr  in   redirect target
//   halted     out  fetch stopped on HLT (constant 0 without CPU_FETCH_HALT_EN)
module cpu_fetch_unit #(
    parameter int unsigned                ADDR_W     = 4,
    parameter int unsigned                DATA_W     = 8,
    parameter logic [ADDR_W-1:0]          RESET_PC   = '0,
    parameter logic [DATA_W-ADDR_W-1:0]   HLT_OPCODE = '1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    output logic [ADDR_W-1:0]          mem_addr,
    input  logic [DATA_W-1:0]          mem_data,
    output logic                       ir_valid,
    input  logic                       ir_ready,
    output logic [DATA_W-ADDR_W-1:0]   opcode,
    output logic [ADDR_W-1:0]          operand,
    output logic [ADDR_W-1:0]          pc,
    input  logic                       jump_en,
    input  logic [ADDR_W-1:0]          jump_addr,
    output logic                       halted
);

`ifdef CPU_FETCH_HALT_EN
    typedef enum logic [1:0] {StAddr, StRead, StValid, StHalt} state_e;
`else
    typedef enum logic [1:0] {StAddr, StRead, StValid} state_e;
`endif

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   mar_q, mar_d;
    logic [DATA_W-1:0]   ir_q, ir_d;
    logic                ir_valid_q, ir_valid_d;
    logic                halt_hit;

`ifdef CPU_FETCH_HALT_EN
    logic halted_q, halted_d;

    assign halt_hit = (ir_q[DATA_W-1:ADDR_W] == HLT_OPCODE);
    assign halted   = halted_q;
`else
    logic unused_hlt_opcode;

    assign unused_hlt_opcode = ^HLT_OPCODE;
    assign halt_hit          = 1'b0;
    assign halted            = 1'b0;
`endif

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StAddr;
            pc_q       <= RESET_PC;
            mar_q      <= RESET_PC;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
`ifdef CPU_FETCH_HALT_EN
            halted_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mar_q      <= mar_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
`ifdef CPU_FETCH_HALT_EN
            halted_q   <= halted_d;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StAddr:  state_d = StRead;
            StRead:  state_d = StValid;
            StValid: begin
                if (ir_ready) begin
`ifdef CPU_FETCH_HALT_EN
                    state_d = halt_hit ? StHalt : StAddr;
`else
                    state_d = StAddr;
`endif
                end
            end
`ifdef CPU_FETCH_HALT_EN
            StHalt:  state_d = StHalt;
`endif
            default: state_d = StAddr;
        endcase
    end

    // Next values of the registered outputs. ir_valid is set on entry to StValid so that it
    // comes straight from a flop rather than a state decode.
    always_comb begin
        pc_d       = pc_q;
        mar_d      = mar_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
`ifdef CPU_FETCH_HALT_EN
        halted_d   = halted_q;
`endif
        unique case (state_q)
            StAddr: mar_d = pc_q;
            StRead: begin
                ir_d       = mem_data;
                pc_d       = pc_q + ADDR_W'(1);
                ir_valid_d = 1'b1;
            end
            StValid: begin
                if (ir_ready) begin
                    ir_valid_d = 1'b0;
                    // Halt wins over a simultaneous jump.
                    if (halt_hit) begin
`ifdef CPU_FETCH_HALT_EN
                        halted_d = 1'b1;
`endif
                    end else if (jump_en) begin
                        pc_d = jump_addr;
                    end
                end
            end
            default: ;
        endcase
    end

    assign mem_addr = mar_q;
    assign ir_valid = ir_valid_q;
    assign opcode   = ir_q[DATA_W-1:ADDR_W];
    assign operand  = ir_q[ADDR_W-1:0];
    assign pc       = pc_q;

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Self-checking bench for cpu_fetch_unit: a small ROM model feeds mem_data, expected
// {IR, pc} pairs are queued as each fetch is set up and popped when ir_valid shows up.
module tb_cpu_fetch_unit;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] mem_addr;
    logic [7:0] mem_data;
    logic       ir_valid;
    logic       ir_ready;
    logic [3:0] opcode;
    logic [3:0] operand;
    logic [3:0] pc;
    logic       jump_en;
    logic [3:0] jump_addr;
    logic       halted;

    logic [7:0] rom [16];

    typedef struct packed {
        logic [7:0] ir;
        logic [3:0] pc;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    assign mem_data = rom[mem_addr];

    cpu_fetch_unit dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .ir_valid  (ir_valid),
        .ir_ready  (ir_ready),
        .opcode    (opcode),
        .operand   (operand),
        .pc        (pc),
        .jump_en   (jump_en),
        .jump_addr (jump_addr),
        .halted    (halted)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] addr);
        exp_t e;
        e.ir = rom[addr];
        e.pc = addr + 4'd1;
        sb.push_back(e);
    endtask

    task automatic wait_valid(input int budget, output int n);
        n = 0;
        while (ir_valid !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check("valid_seen", {31'd0, ir_valid}, 32'd1);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        e = sb.pop_front();
        check(tag, {20'd0, opcode, operand, pc}, {20'd0, e.ir, e.pc});
    endtask

    initial begin
        int n;
        reset_n   = 1'b0;
        ir_ready  = 1'b1;
        jump_en   = 1'b0;
        jump_addr = 4'd0;
        for (int i = 0; i < 16; i++) rom[i] = 8'(i * 17);
        rom[0] = 8'h1A;

        // Reset state.
        tick();
        check("reset_state", {18'd0, ir_valid, halted, opcode, operand, pc, mem_addr}, 32'd0);

        // Release right after an edge: that edge is edge 1, edges 2 and 3 walk ADDR->READ->VALID.
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        push(4'd0);
        check("edge1_quiet", {18'd0, ir_valid, halted, opcode, operand, pc, mem_addr}, 32'd0);
        tick();
        check("edge2_quiet", {18'd0, ir_valid, halted, opcode, operand, pc, mem_addr}, 32'd0);
        tick();
        check("edge3_valid", {31'd0, ir_valid}, 32'd1);
        pop_check("first_ir");
        check("first_addr", {28'd0, mem_addr}, 32'd0);
        rom[0] = 8'h00;

        // Sequential run with ready high, including the 15 -> 0 wrap.
        for (int i = 1; i <= 16; i++) begin
            tick();
            push(4'(i));
            wait_valid(6, n);
            check("period", n, 32'd2);
            pop_check("seq_ir");
        end

        // Backpressure on ROM[2].
        rom[2] = 8'h3C;
        rom[4] = 8'h6E;
        tick();
        push(4'd1);
        wait_valid(6, n);
        pop_check("bp_pre");
        tick();
        ir_ready = 1'b0;
        push(4'd2);
        wait_valid(6, n);
        pop_check("bp_ir");
        for (int k = 0; k < 10; k++) begin
            tick();
            check("bp_hold", {15'd0, ir_valid, opcode, operand, pc, mem_addr},
                  {15'd0, 1'b1, 4'h3, 4'hC, 4'd3, 4'd2});
        end
        ir_ready = 1'b1;
        tick();
        ir_ready = 1'b0;
        check("bp_release", {31'd0, ir_valid}, 32'd0);
        tick();
        check("bp_next_addr", {28'd0, mem_addr}, 32'd3);
        push(4'd3);
        wait_valid(6, n);
        pop_check("bp_next_ir");
        ir_ready = 1'b1;
        tick();
        ir_ready = 1'b0;
        push(4'd4);
        wait_valid(6, n);
        pop_check("jmp_src_ir");

        // Jump without ready is ignored, then taken on the handshake.
        jump_en   = 1'b1;
        jump_addr = 4'd9;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("jmp_noready", {27'd0, ir_valid, pc}, {27'd0, 1'b1, 4'd5});
        end
        ir_ready = 1'b1;
        tick();
        check("jmp_pc", {27'd0, ir_valid, pc}, {27'd0, 1'b0, 4'd9});
        // jump_en held through ADDR and READ must not redirect again.
        jump_addr = 4'd3;
        tick();
        check("jmp_mar", {28'd0, mem_addr}, 32'd9);
        tick();
        jump_en = 1'b0;
        push(4'd9);
        wait_valid(6, n);
        pop_check("jmp_ir");

        // Async reset while in READ.
        tick();
        tick();
        rom[10] = 8'h77;
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst", {15'd0, ir_valid, opcode, operand, pc, mem_addr}, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        rom[10] = 8'hAA;
        push(4'd0);
        wait_valid(6, n);
        check("restart_lat", n, 32'd2);
        pop_check("restart_ir");
        check("restart_addr", {28'd0, mem_addr}, 32'd0);

        // HLT at address 1.
        rom[1] = 8'hF0;
        rom[2] = 8'h22;
        reset_n = 1'b0;
        tick();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        push(4'd0);
        wait_valid(6, n);
        pop_check("hlt_pre");
        tick();
        push(4'd1);
        wait_valid(6, n);
        pop_check("hlt_ir");
`ifdef CPU_FETCH_HALT_EN
        jump_en   = 1'b1;
        jump_addr = 4'd5;
        tick();
        check("halt_entry", {26'd0, halted, ir_valid, pc}, {26'd0, 1'b1, 1'b0, 4'd2});
        for (int k = 0; k < 20; k++) begin
            tick();
            check("halt_hold", {14'd0, halted, ir_valid, pc, mem_addr, opcode, operand},
                  {14'd0, 1'b1, 1'b0, 4'd2, 4'd1, 4'hF, 4'h0});
        end
        jump_en = 1'b0;
`else
        tick();
        check("no_halt", {30'd0, halted, ir_valid}, 32'd0);
        push(4'd2);
        wait_valid(6, n);
        pop_check("no_halt_ir");
        check("no_halt_flag", {31'd0, halted}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
